// File: rtl/requant_writeback.sv
// Requantizes up to four INT32 lane accumulators to INT8 and writes the packed word to memory.
// Build option: define REQUANT_BIAS_EN to fetch per-lane INT32 biases from memory before requantizing.
module requant_writeback #(
    parameter int MULT_W    = 16,
    parameter int SAT_CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [31:0]          in_acc0,
    input  logic [31:0]          in_acc1,
    input  logic [31:0]          in_acc2,
    input  logic [31:0]          in_acc3,
    input  logic [2:0]           in_lanes,
    input  logic [31:0]          in_out_addr,
    input  logic [31:0]          in_bias_addr,
    input  logic [MULT_W-1:0]    cfg_mult,
    input  logic [4:0]           cfg_shift,
    input  logic                 cfg_relu,
    output logic [31:0]          dma_addr,
    output logic                 dma_re,
    output logic [3:0]           dma_we,
    output logic [31:0]          dma_wdata,
    input  logic [31:0]          dma_rdata,
    output logic                 busy,
    output logic                 done,
    output logic [SAT_CNT_W-1:0] sat_count,
    input  logic                 sat_clr
);
    localparam int P_W = 33 + MULT_W + 1;

    typedef enum logic [2:0] {
        IDLE,
`ifdef REQUANT_BIAS_EN
        BIAS_RD,
        BIAS_WAIT,
`endif
        CALC,
        WRITE,
        DONE
    } state_t;

    state_t            state_reg;
    logic [2:0]        lane_reg;
    logic [2:0]        lanes_reg;
    logic [31:0]       acc_reg [4];
    logic [31:0]       out_addr_reg;
    logic [MULT_W-1:0] mult_reg;
    logic [4:0]        shift_reg;
    logic              relu_reg;
    logic [31:0]       word_reg;

`ifdef REQUANT_BIAS_EN
    logic [31:0]       bias_reg [4];
    logic [31:0]       bias_addr_reg;
`else
    logic              unused_inputs;
    assign unused_inputs = ^{in_bias_addr, dma_rdata};
`endif

    logic [2:0]        lanes_eff;
    logic [2:0]        lane_inc;
    logic [3:0]        lane_mask;

    assign lanes_eff = (in_lanes > 3'd4) ? 3'd4 : in_lanes;
    assign lane_inc  = lane_reg + 3'd1;

    for (genvar gi = 0; gi < 4; gi++) begin : g_mask
        assign lane_mask[gi] = (3'(gi) < lanes_reg);
    end

    // Requantize the lane selected by lane_reg; all intermediates are wide enough to be exact.
    logic [31:0]           acc_sel;
    logic [31:0]           bias_sel;
    logic signed [32:0]    sum;
    logic signed [P_W-1:0] prod;
    logic signed [P_W-1:0] rnd;
    logic signed [P_W-1:0] rounded;
    logic [7:0]            lane_q;
    logic                  clipped;
    logic [31:0]           word_next;

    always_comb begin
        acc_sel = acc_reg[lane_reg[1:0]];
`ifdef REQUANT_BIAS_EN
        bias_sel = bias_reg[lane_reg[1:0]];
`else
        bias_sel = '0;
`endif
        sum  = $signed({acc_sel[31], acc_sel}) + $signed({bias_sel[31], bias_sel});
        prod = $signed({{(P_W-33){sum[32]}}, sum}) * $signed({{(P_W-MULT_W){1'b0}}, mult_reg});
        rnd  = '0;
        if (shift_reg != 5'd0) begin
            rnd = P_W'(1) << (shift_reg - 5'd1);
        end
        rounded = (prod + rnd) >>> shift_reg;
        if (relu_reg && rounded[P_W-1]) begin
            rounded = '0;
        end
        clipped = 1'b0;
        lane_q  = rounded[7:0];
        if (!rounded[P_W-1] && (|rounded[P_W-2:7])) begin
            lane_q  = 8'h7F;
            clipped = 1'b1;
        end else if (rounded[P_W-1] && !(&rounded[P_W-2:7])) begin
            lane_q  = 8'h80;
            clipped = 1'b1;
        end
        word_next = word_reg;
        word_next[{lane_reg[1:0], 3'b000} +: 8] = lane_q;
    end

    always_ff @(posedge clk) begin
        if (reset || sat_clr) begin
            sat_count <= '0;
        end else if (state_reg == CALC && clipped && !(&sat_count)) begin
            sat_count <= sat_count + SAT_CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= IDLE;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
            done      <= 1'b0;
            dma_re    <= 1'b0;
            dma_we    <= '0;
            dma_addr  <= '0;
            dma_wdata <= '0;
            lane_reg  <= '0;
            lanes_reg <= '0;
            word_reg  <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        acc_reg[0]   <= in_acc0;
                        acc_reg[1]   <= in_acc1;
                        acc_reg[2]   <= in_acc2;
                        acc_reg[3]   <= in_acc3;
                        out_addr_reg <= in_out_addr;
                        mult_reg     <= cfg_mult;
                        shift_reg    <= cfg_shift;
                        relu_reg     <= cfg_relu;
                        lanes_reg    <= lanes_eff;
                        lane_reg     <= '0;
                        word_reg     <= '0;
                        in_ready     <= 1'b0;
                        busy         <= 1'b1;
`ifdef REQUANT_BIAS_EN
                        bias_addr_reg <= in_bias_addr;
`endif
                        if (lanes_eff == 3'd0) begin
                            state_reg <= DONE;
                            done      <= 1'b1;
                        end else begin
`ifdef REQUANT_BIAS_EN
                            state_reg <= BIAS_RD;
                            dma_re    <= 1'b1;
                            dma_addr  <= in_bias_addr;
`else
                            state_reg <= CALC;
`endif
                        end
                    end
                end
`ifdef REQUANT_BIAS_EN
                BIAS_RD: begin
                    dma_re    <= 1'b0;
                    state_reg <= BIAS_WAIT;
                end
                BIAS_WAIT: begin
                    bias_reg[lane_reg[1:0]] <= dma_rdata;
                    if (lane_inc == lanes_reg) begin
                        lane_reg  <= '0;
                        state_reg <= CALC;
                    end else begin
                        lane_reg  <= lane_inc;
                        dma_re    <= 1'b1;
                        dma_addr  <= bias_addr_reg + {27'd0, lane_inc, 2'b00};
                        state_reg <= BIAS_RD;
                    end
                end
`endif
                CALC: begin
                    word_reg <= word_next;
                    if (lane_inc == lanes_reg) begin
                        state_reg <= WRITE;
                        dma_we    <= lane_mask;
                        dma_addr  <= out_addr_reg;
                        dma_wdata <= word_next;
                    end else begin
                        lane_reg <= lane_inc;
                    end
                end
                WRITE: begin
                    dma_we    <= '0;
                    done      <= 1'b1;
                    state_reg <= DONE;
                end
                DONE: begin
                    done      <= 1'b0;
                    in_ready  <= 1'b1;
                    busy      <= 1'b0;
                    state_reg <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_requant_writeback.sv
// Randomized self-checking bench for requant_writeback; the model computes each packed word from plain arithmetic.
`timescale 1ns/1ps
module tb_requant_writeback;
    localparam int MULT_W  = 16;
    localparam int SAT_W   = 4;
    localparam int SAT_MAX = (1 << SAT_W) - 1;
`ifdef REQUANT_BIAS_EN
    localparam bit BIAS_EN = 1'b1;
`else
    localparam bit BIAS_EN = 1'b0;
`endif

    logic              clk;
    logic              reset;
    logic              in_valid;
    logic              in_ready;
    logic [31:0]       in_acc0, in_acc1, in_acc2, in_acc3;
    logic [2:0]        in_lanes;
    logic [31:0]       in_out_addr;
    logic [31:0]       in_bias_addr;
    logic [MULT_W-1:0] cfg_mult;
    logic [4:0]        cfg_shift;
    logic              cfg_relu;
    logic [31:0]       dma_addr;
    logic              dma_re;
    logic [3:0]        dma_we;
    logic [31:0]       dma_wdata;
    logic [31:0]       dma_rdata;
    logic              busy;
    logic              done;
    logic [SAT_W-1:0]  sat_count;
    logic              sat_clr;

    requant_writeback #(.MULT_W(MULT_W), .SAT_CNT_W(SAT_W)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_acc0(in_acc0), .in_acc1(in_acc1), .in_acc2(in_acc2), .in_acc3(in_acc3),
        .in_lanes(in_lanes), .in_out_addr(in_out_addr), .in_bias_addr(in_bias_addr),
        .cfg_mult(cfg_mult), .cfg_shift(cfg_shift), .cfg_relu(cfg_relu),
        .dma_addr(dma_addr), .dma_re(dma_re), .dma_we(dma_we), .dma_wdata(dma_wdata),
        .dma_rdata(dma_rdata), .busy(busy), .done(done), .sat_count(sat_count), .sat_clr(sat_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int          vectors = 0;
    int          miscompares = 0;
    int          busy_from = 1;
    int          busy_to = 0;
    int          accept_cyc = 0;
    int          done_cyc = 0;
    bit          op_pending = 0;
    bit          write_pending = 0;
    logic [31:0] exp_word;
    logic [31:0] exp_addr;
    logic [3:0]  exp_mask;
    int          model_sat = 0;
    logic [31:0] rd_addr_q[$];
    int          rd_cyc_q[$];
    bit          lit_en = 0;
    logic [31:0] lit_word;
    logic [3:0]  lit_mask;
    int          lit_sat = 0;
    int          lit_lat = -1;
    logic [31:0] mem [logic [31:0]];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s at cycle %0d: got 0x%08h expected 0x%08h", name, cyc, act, exp);
        end
    endtask

    // Reference requantization of one lane straight from the arithmetic rules.
    function automatic logic [7:0] model_lane(input longint acc, input longint bias, input longint mult,
                                              input int sh, input bit relu, output bit clip);
        longint v;
        v = (acc + bias) * mult;
        if (sh > 0) v = v + (longint'(1) <<< (sh - 1));
        v = v >>> sh;
        if (relu && v < 0) v = 0;
        clip = 1'b0;
        if (v > 127) begin
            v = 127;
            clip = 1'b1;
        end else if (v < -128) begin
            v = -128;
            clip = 1'b1;
        end
        return v[7:0];
    endfunction

    task automatic expect_accept();
        logic [31:0] a[4];
        longint b;
        bit c;
        int l, lat, clips;
        a[0] = in_acc0; a[1] = in_acc1; a[2] = in_acc2; a[3] = in_acc3;
        l = (in_lanes > 3'd4) ? 4 : int'(in_lanes);
        exp_word = '0;
        exp_mask = '0;
        exp_addr = in_out_addr;
        clips = 0;
        for (int i = 0; i < l; i++) begin
            b = 0;
`ifdef REQUANT_BIAS_EN
            b = longint'($signed(mem[in_bias_addr + 32'(4 * i)]));
            rd_addr_q.push_back(in_bias_addr + 32'(4 * i));
            rd_cyc_q.push_back(cyc + 1 + 2 * i);
`endif
            exp_word[8*i +: 8] = model_lane(longint'($signed(a[i])), b, longint'(cfg_mult),
                                            int'(cfg_shift), cfg_relu, c);
            exp_mask[i] = 1'b1;
            if (c) clips++;
        end
        lat = (l == 0) ? 1 : (BIAS_EN ? 3 * l + 2 : l + 2);
        model_sat = (model_sat + clips > SAT_MAX) ? SAT_MAX : model_sat + clips;
        accept_cyc    = cyc;
        done_cyc      = cyc + lat;
        busy_from     = cyc + 1;
        busy_to       = cyc + lat;
        op_pending    = 1'b1;
        write_pending = (l > 0);
    endtask

    // Bias memory: answers a read in the cycle after dma_re.
    initial begin
        logic [31:0] a;
        bit pend;
        dma_rdata = '0;
        forever begin
            @(negedge clk);
            pend = dma_re;
            a    = dma_addr;
            @(posedge clk);
            #1;
            if (pend && mem.exists(a)) dma_rdata = mem[a];
            else dma_rdata = $urandom();
        end
    end

    // Per-cycle compare against the model.
    initial begin
        bit exp_b;
        forever begin
            @(negedge clk);
            if (reset) continue;
            exp_b = (cyc >= busy_from) && (cyc <= busy_to);
            chk("busy", 32'(busy), 32'(exp_b));
            chk("in_ready", 32'(in_ready), 32'(!exp_b));
            if (dma_re) begin
                chk("re_we_exclusive", 32'(dma_we), 32'h0);
                if (rd_addr_q.size() == 0) chk("unexpected_read", 32'(dma_re), 32'h0);
                else begin
                    chk("read_addr", dma_addr, rd_addr_q.pop_front());
                    chk("read_cycle", 32'(cyc), 32'(rd_cyc_q.pop_front()));
                end
            end
            if (dma_we != 4'h0) begin
                if (!write_pending) chk("unexpected_write", 32'(dma_we), 32'h0);
                else begin
                    chk("write_cycle", 32'(cyc), 32'(done_cyc - 1));
                    chk("write_addr", dma_addr, exp_addr);
                    chk("write_mask", 32'(dma_we), 32'(exp_mask));
                    chk("write_data", dma_wdata, exp_word);
                    if (lit_en) begin
                        chk("literal_data", dma_wdata, lit_word);
                        chk("literal_mask", 32'(dma_we), 32'(lit_mask));
                    end
                    write_pending = 1'b0;
                end
            end
            if (done) begin
                if (!op_pending) chk("unexpected_done", 32'(done), 32'h0);
                else begin
                    chk("done_cycle", 32'(cyc), 32'(done_cyc));
                    chk("write_issued", 32'(write_pending), 32'h0);
                    chk("reads_issued", 32'(rd_addr_q.size()), 32'h0);
                    chk("sat_count", 32'(sat_count), 32'(model_sat));
                    if (lit_lat >= 0) chk("literal_latency", 32'(cyc - accept_cyc), 32'(lit_lat));
                    if (lit_en) chk("literal_sat", 32'(sat_count), 32'(lit_sat));
                    lit_en     = 1'b0;
                    lit_lat    = -1;
                    op_pending = 1'b0;
                end
            end
        end
    end

    task automatic scramble();
        in_acc0      = $urandom();
        in_acc1      = $urandom();
        in_acc2      = $urandom();
        in_acc3      = $urandom();
        in_lanes     = 3'($urandom());
        in_out_addr  = $urandom();
        in_bias_addr = $urandom();
        cfg_mult     = MULT_W'($urandom());
        cfg_shift    = 5'($urandom());
        cfg_relu     = 1'($urandom());
    endtask

    task automatic setup_op(input logic [31:0] a0, input logic [31:0] a1, input logic [31:0] a2,
                            input logic [31:0] a3, input logic [2:0] lanes, input logic [MULT_W-1:0] mult,
                            input logic [4:0] sh, input logic relu, input logic [31:0] b0,
                            input logic [31:0] b1, input logic [31:0] b2, input logic [31:0] b3);
        in_acc0 = a0; in_acc1 = a1; in_acc2 = a2; in_acc3 = a3;
        in_lanes = lanes; cfg_mult = mult; cfg_shift = sh; cfg_relu = relu;
        in_out_addr  = $urandom() & 32'hFFFF_FFFC;
        in_bias_addr = $urandom() & 32'hFFFF_FFFC;
        mem[in_bias_addr]         = b0;
        mem[in_bias_addr + 32'd4]  = b1;
        mem[in_bias_addr + 32'd8]  = b2;
        mem[in_bias_addr + 32'd12] = b3;
    endtask

    task automatic send(input bit hold);
        int t;
        t = 0;
        while (!in_ready && t < 100) begin
            @(posedge clk); #1;
            t++;
        end
        chk("ready_before_send", 32'(in_ready), 32'h1);
        if (!in_ready) return;
        in_valid = 1'b1;
        expect_accept();
        @(posedge clk); #1;
        if (hold) begin
            t = 0;
            while (cyc < done_cyc + 1 && t < 100) begin
                @(posedge clk); #1;
                t++;
            end
            // Still-held valid is taken again once the block is back in IDLE.
            expect_accept();
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        scramble();
    endtask

    task automatic wait_idle();
        int t;
        t = 0;
        while (op_pending && t < 200) begin
            @(posedge clk); #1;
            t++;
        end
        chk("done_timeout", 32'(op_pending), 32'h0);
        if (op_pending) begin
            op_pending = 1'b0;
            write_pending = 1'b0;
            rd_addr_q.delete();
            rd_cyc_q.delete();
            busy_to = cyc;
        end
    endtask

    task automatic sat_clear();
        sat_clr = 1'b1;
        @(posedge clk); #1;
        sat_clr = 1'b0;
        model_sat = 0;
        chk("sat_cleared", 32'(sat_count), 32'h0);
    endtask

    task automatic directed(input logic [31:0] a0, input logic [31:0] a1, input logic [31:0] a2,
                            input logic [31:0] a3, input logic [2:0] lanes, input logic [4:0] sh,
                            input logic relu, input logic [31:0] b0, input logic [31:0] b1,
                            input logic [31:0] lw, input logic [3:0] lm, input int ls, input int ll);
        sat_clear();
        setup_op(a0, a1, a2, a3, lanes, MULT_W'(1), sh, relu, b0, b1, 32'd0, 32'd0);
        lit_en = 1'b1; lit_word = lw; lit_mask = lm; lit_sat = ls; lit_lat = ll;
        send(1'b0);
        wait_idle();
    endtask

    function automatic logic [31:0] rand_val();
        int v;
        case ($urandom_range(0, 2))
            0: begin v = $urandom_range(0, 600); return 32'(v - 300); end
            1: return $urandom();
            default: begin v = $urandom_range(0, 1 << 21); return 32'(v - (1 << 20)); end
        endcase
    endfunction

    task automatic rand_op(input logic [2:0] lanes);
        logic [31:0] a[4];
        logic [31:0] b[4];
        logic [MULT_W-1:0] m;
        logic [4:0] sh;
        for (int i = 0; i < 4; i++) begin
            a[i] = rand_val();
            b[i] = rand_val();
        end
        case ($urandom_range(0, 2))
            0: m = MULT_W'(1);
            1: m = MULT_W'($urandom_range(0, 255));
            default: m = MULT_W'($urandom());
        endcase
        sh = ($urandom_range(0, 1) == 0) ? 5'($urandom_range(0, 4)) : 5'($urandom());
        setup_op(a[0], a[1], a[2], a[3], lanes, m, sh, 1'($urandom_range(0, 1)), b[0], b[1], b[2], b[3]);
    endtask

    initial begin
        int offs;
        reset = 1'b1; in_valid = 1'b0; sat_clr = 1'b0;
        scramble();
        repeat (3) @(posedge clk);
        #1;
        chk("reset_in_ready", 32'(in_ready), 32'h1);
        chk("reset_busy", 32'(busy), 32'h0);
        chk("reset_done", 32'(done), 32'h0);
        chk("reset_dma_re", 32'(dma_re), 32'h0);
        chk("reset_dma_we", 32'(dma_we), 32'h0);
        chk("reset_dma_addr", dma_addr, 32'h0);
        chk("reset_dma_wdata", dma_wdata, 32'h0);
        chk("reset_sat_count", 32'(sat_count), 32'h0);
        reset = 1'b0;
        @(posedge clk); #1;

        directed(32'd5, -32'sd3, 32'd200, -32'sd200, 3'd4, 5'd0, 1'b0, 32'd0, 32'd0,
                 32'h807F_FD05, 4'hF, 2, BIAS_EN ? 14 : 6);
        directed(32'd3, -32'sd3, 32'd0, 32'd0, 3'd2, 5'd1, 1'b0, 32'd0, 32'd0,
                 32'h0000_FF02, 4'h3, 0, BIAS_EN ? 8 : 4);
        directed(-32'sd3, 32'd77, 32'd1000, 32'd9, 3'd1, 5'd0, 1'b1, 32'd0, 32'd0,
                 32'h0000_0000, 4'h1, 0, BIAS_EN ? 5 : 3);
        directed(32'd1000, 32'd1000, 32'd1000, 32'd1000, 3'd0, 5'd0, 1'b0, 32'd0, 32'd0,
                 32'h0000_0000, 4'h0, 0, 1);
`ifdef REQUANT_BIAS_EN
        directed(32'd1, 32'd1, 32'd0, 32'd0, 3'd2, 5'd0, 1'b0, 32'd10, -32'sd10,
                 32'h0000_F70B, 4'h3, 0, 8);
`endif

        rand_op(3'd3);
        send(1'b1);
        wait_idle();

        // Abort in the middle of CALC: no write may follow and the block must be idle next cycle.
        rand_op(3'd4);
        send(1'b0);
        offs = (BIAS_EN ? 8 : 0) + 2;
        while (cyc < accept_cyc + offs) begin
            @(posedge clk); #1;
        end
        reset = 1'b1;
        busy_to = cyc;
        op_pending = 1'b0;
        write_pending = 1'b0;
        rd_addr_q.delete();
        rd_cyc_q.delete();
        lit_en = 1'b0;
        lit_lat = -1;
        model_sat = 0;
        @(posedge clk); #1;
        reset = 1'b0;
        chk("abort_busy", 32'(busy), 32'h0);
        chk("abort_in_ready", 32'(in_ready), 32'h1);
        chk("abort_dma_we", 32'(dma_we), 32'h0);
        rand_op(3'd4);
        send(1'b0);
        wait_idle();

        for (int n = 0; n < 150; n++) begin
            if ($urandom_range(0, 9) == 0) sat_clear();
            rand_op(3'($urandom_range(0, 7)));
            send($urandom_range(0, 9) == 0);
            wait_idle();
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk); #1;
            end
        end

        repeat (4) @(posedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation exceeded its time limit at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/requant_writeback.md
Name: requant_writeback

Overview:
- Downstream stage of the 4-lane INT8 dot-product accelerator.
- Accepts up to four INT32 lane accumulators, optionally adds per-lane INT32 biases fetched from data memory, then requantizes each lane: multiply, rounding arithmetic right shift, optional ReLU, saturate to INT8.
- Packs the INT8 lanes into one 32-bit word and writes it back through the shared dcache port, so layer outputs land in memory without CPU involvement.

Parameters:
MULT_W, 16, width of unsigned requant multiplier cfg_mult
SAT_CNT_W, 16, width of saturation event counter

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
in_valid  in  1  accumulator bundle valid
in_ready  out  1  block can accept a bundle
in_acc0  in  32  lane 0 accumulator, signed
in_acc1  in  32  lane 1 accumulator, signed
in_acc2  in  32  lane 2 accumulator, signed
in_acc3  in  32  lane 3 accumulator, signed
in_lanes  in  3  active lane count, 1..4
in_out_addr  in  32  word-aligned output byte address
in_bias_addr  in  32  word-aligned base of INT32 bias array
cfg_mult  in  MULT_W  unsigned multiplier
cfg_shift  in  5  right-shift amount
cfg_relu  in  1  clamp negatives to 0
dma_addr  out  32  memory address
dma_re  out  1  memory read strobe
dma_we  out  4  memory byte write enables
dma_wdata  out  32  memory write data
dma_rdata  in  32  read data, valid one cycle after dma_re
busy  out  1  high in any state except IDLE
done  out  1  one-cycle completion pulse
sat_count  out  SAT_CNT_W  count of clipped lanes
sat_clr  in  1  clears sat_count

Behaviour:
- Clock is clk. Reset is synchronous and active-high on reset.
- Reset values: in_ready=1, busy=0, done=0, dma_re=0, dma_we=0, dma_addr=0, dma_wdata=0, sat_count=0, state=IDLE.
- Reset mid-operation aborts: the next cycle is IDLE with all strobes low. No partial write is issued.
- All outputs are registered.
- States: IDLE, BIAS_RD, BIAS_WAIT, CALC, WRITE, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready, latch accumulators, addresses, cfg_mult, cfg_shift and cfg_relu. cfg_* changes after acceptance are ignored.
  - L = in_lanes, clamped: values >4 are treated as 4; L=0 goes directly to DONE with no memory access.
  - Otherwise set lane=0 and go to BIAS_RD (feature on) or CALC (feature off).
- in_ready=0 in every state other than IDLE. in_valid is ignored there.
- BIAS_RD: dma_re=1 for exactly one cycle, dma_addr=bias_addr+4*lane. Next state is BIAS_WAIT.
- BIAS_WAIT:
  - Capture dma_rdata as bias[lane].
  - If lane+1==L, set lane=0 and go to CALC. Otherwise increment lane and go to BIAS_RD.
- CALC: processes one lane per cycle for L cycles.
  - s = acc+bias, 33-bit signed, no wrap.
  - p = s*cfg_mult, signed x unsigned, 33+MULT_W+1 bits, exact.
  - r = (p + (cfg_shift>0 ? 1<<(cfg_shift-1) : 0)) >>> cfg_shift. This is round-half-up.
  - If cfg_relu and r<0, r=0.
  - Saturate r to [-128,127]. Each lane clipped by this step increments sat_count; the counter saturates at its maximum rather than wrapping.
  - Lane i result goes to byte i of the output word.
- WRITE:
  - One cycle with dma_addr=out_addr.
  - dma_we bit i is set for i<L.
  - Inactive bytes of dma_wdata are 0x00.
- DONE: done=1 for one cycle, then IDLE. dma_re and dma_we are low.
- Latency from the acceptance cycle to the done cycle:
  - 3L+2 cycles with the feature compiled in.
  - L+2 cycles with the feature compiled out.
  - L=0 gives 1 cycle.
- dma_re and dma_we are never high in the same cycle.
- sat_clr has priority over a simultaneous increment.

Optional Feature:
- Macro: REQUANT_BIAS_EN.
- Defined: the BIAS_RD/BIAS_WAIT loop runs, and in_bias_addr is used.
- Undefined: no bias fetch states exist, bias is 0 for every lane, in_bias_addr is unused, and dma_re is tied 0.

Test Plan:
- mult=1, shift=0, relu=0, L=4, acc={5,-3,200,-200}, bias 0 -> one write with dma_we=0xF, dma_wdata=0x807FFD05; sat_count increases by 2.
- mult=1, shift=1, L=2, acc={3,-3} -> dma_wdata=0x0000FF02, dma_we=0x3.
- relu=1, mult=1, shift=0, L=1, acc0=-3 -> dma_wdata byte0=0x00, dma_we=0x1, sat_count unchanged.
- REQUANT_BIAS_EN, memory at bias_addr={10,-10}, acc={1,1}, L=2, mult=1, shift=0:
  - two dma_re pulses at bias_addr and bias_addr+4, one cycle apart plus wait;
  - dma_wdata=0x0000F70B;
  - done exactly 8 cycles after acceptance.
- in_valid held high through an operation -> only one acceptance; in_ready=0 until the cycle after done; a second bundle is accepted in IDLE.
- reset asserted during CALC -> no dma_we pulse; next cycle busy=0, in_ready=1; a fresh bundle then completes normally.
